// File: rtl/ckn_ad_buf.sv
// ckn_ad_buf: show-ahead FIFO of {last, data[31:0]} entries between the DMA
// read path and the write-request stage. Tracks occupancy, complete-packet
// count and sticky overflow/underflow flags.
// Optional build macro CKN_AD_BUF_STATS_EN adds free-running push/pop counters.
module ckn_ad_buf #(
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                   iClk,
    input  logic                   iRstn,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [31:0]            push_data_i,
    input  logic                   push_last_i,
    input  logic                   ckn_ad_fetch_i,
    output logic                   ckn_ad_avail_o,
    output logic [32:0]            ckn_data_o,
    output logic                   full_o,
    output logic                   afull_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [$clog2(DEPTH):0] pkt_cnt_o,
`ifdef CKN_AD_BUF_STATS_EN
    output logic [31:0]            push_cnt_o,
    output logic [31:0]            pop_cnt_o,
`endif
    output logic                   ovf_err_o,
    output logic                   udf_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AFULL_LV = PW'(AFULL_TH);

    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, lvl_nxt, pkt_nxt;
    logic          push_acc, pop, head_last;

    // Accept/pop qualification; fetch on empty never pops, push into full
    // only lands when the head is leaving in the same cycle.
    always_comb begin
        push_acc  = push_i && (!full_o || ckn_ad_fetch_i);
        pop       = ckn_ad_fetch_i && ckn_ad_avail_o;
        head_last = ckn_data_o[32];
        wr_nxt    = wr_ptr + PW'(push_acc);
        rd_nxt    = rd_ptr + PW'(pop);
        lvl_nxt   = wr_nxt - rd_nxt;
        pkt_nxt   = pkt_cnt_o;
        case ({push_acc && push_last_i, pop && head_last})
            2'b10:   pkt_nxt = pkt_cnt_o + PW'(1);
            2'b01:   pkt_nxt = pkt_cnt_o - PW'(1);
            default: pkt_nxt = pkt_cnt_o;
        endcase
    end

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge iClk) begin
        if (push_acc && !flush_i)
            mem[wr_ptr[AW-1:0]] <= {push_last_i, push_data_i};
    end

    // Pointers, occupancy flags, packet count and sticky errors.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level_o        <= '0;
            pkt_cnt_o      <= '0;
            ckn_ad_avail_o <= 1'b0;
            full_o         <= 1'b0;
            afull_o        <= 1'b0;
            ovf_err_o      <= 1'b0;
            udf_err_o      <= 1'b0;
        end else if (flush_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level_o        <= '0;
            pkt_cnt_o      <= '0;
            ckn_ad_avail_o <= 1'b0;
            full_o         <= 1'b0;
            afull_o        <= 1'b0;
            ovf_err_o      <= 1'b0;
            udf_err_o      <= 1'b0;
        end else begin
            wr_ptr         <= wr_nxt;
            rd_ptr         <= rd_nxt;
            level_o        <= lvl_nxt;
            pkt_cnt_o      <= pkt_nxt;
            ckn_ad_avail_o <= (wr_nxt != rd_nxt);
            full_o         <= (wr_nxt[AW] != rd_nxt[AW]) &&
                              (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            afull_o        <= (lvl_nxt >= AFULL_LV);
            if (push_i && full_o && !ckn_ad_fetch_i)
                ovf_err_o <= 1'b1;
            if (ckn_ad_fetch_i && !ckn_ad_avail_o)
                udf_err_o <= 1'b1;
        end
    end

    // Show-ahead head: raw memory read at the registered read pointer, zero when empty.
    always_comb begin
        ckn_data_o = ckn_ad_avail_o ? mem[rd_ptr[AW-1:0]] : 33'd0;
    end

`ifdef CKN_AD_BUF_STATS_EN
    // Free-running accepted push/pop counters, wrapping at 2^32.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            push_cnt_o <= '0;
            pop_cnt_o  <= '0;
        end else if (flush_i) begin
            push_cnt_o <= '0;
            pop_cnt_o  <= '0;
        end else begin
            push_cnt_o <= push_cnt_o + 32'(push_acc);
            pop_cnt_o  <= pop_cnt_o + 32'(pop);
        end
    end
`endif

endmodule

// File: tb/tb_ckn_ad_buf.sv
// Randomized bench for ckn_ad_buf against a queue-based reference model.
module tb_ckn_ad_buf;

    logic        iClk = 1'b0;
    logic        iRstn;
    logic        flush_i, push_i, push_last_i, ckn_ad_fetch_i;
    logic [31:0] push_data_i;
    logic        ckn_ad_avail_o, full_o, afull_o, ovf_err_o, udf_err_o;
    logic [32:0] ckn_data_o;
    logic [4:0]  level_o, pkt_cnt_o;
`ifdef CKN_AD_BUF_STATS_EN
    logic [31:0] push_cnt_o, pop_cnt_o;
    int unsigned m_push_cnt, m_pop_cnt;
`endif

    ckn_ad_buf #(.DEPTH(16)) dut (
        .iClk(iClk), .iRstn(iRstn), .flush_i(flush_i), .push_i(push_i),
        .push_data_i(push_data_i), .push_last_i(push_last_i),
        .ckn_ad_fetch_i(ckn_ad_fetch_i), .ckn_ad_avail_o(ckn_ad_avail_o),
        .ckn_data_o(ckn_data_o), .full_o(full_o), .afull_o(afull_o),
        .level_o(level_o), .pkt_cnt_o(pkt_cnt_o),
`ifdef CKN_AD_BUF_STATS_EN
        .push_cnt_o(push_cnt_o), .pop_cnt_o(pop_cnt_o),
`endif
        .ovf_err_o(ovf_err_o), .udf_err_o(udf_err_o)
    );

    always #5 iClk = ~iClk;

    // Reference model: the FIFO contents as a queue plus sticky flags.
    logic [32:0] mq[$];
    logic        m_ovf, m_udf;
    int          n_cmp, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i][32]) n++;
        return n;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
`ifdef CKN_AD_BUF_STATS_EN
        m_push_cnt = 0;
        m_pop_cnt  = 0;
`endif
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".level"}, 64'(level_o), 64'(mq.size()));
        chk({ctx, ".pkt"},   64'(pkt_cnt_o), 64'(m_pkts()));
        chk({ctx, ".avail"}, 64'(ckn_ad_avail_o), 64'(mq.size() > 0));
        chk({ctx, ".data"},  64'(ckn_data_o), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
        chk({ctx, ".full"},  64'(full_o), 64'(mq.size() == 16));
        chk({ctx, ".afull"}, 64'(afull_o), 64'(mq.size() >= 14));
        chk({ctx, ".ovf"},   64'(ovf_err_o), 64'(m_ovf));
        chk({ctx, ".udf"},   64'(udf_err_o), 64'(m_udf));
`ifdef CKN_AD_BUF_STATS_EN
        chk({ctx, ".pushc"}, 64'(push_cnt_o), 64'(m_push_cnt));
        chk({ctx, ".popc"},  64'(pop_cnt_o), 64'(m_pop_cnt));
`endif
    endtask

    // One clock: drive, let the edge happen, advance the model, check after the edge.
    task automatic step(input string ctx, input logic p, input logic [31:0] d,
                        input logic l, input logic f, input logic fl);
        bit do_pop, do_push;
        push_i = p; push_data_i = d; push_last_i = l;
        ckn_ad_fetch_i = f; flush_i = fl;
        @(posedge iClk);
        if (fl) begin
            m_clear();
        end else begin
            do_pop  = f && (mq.size() > 0);
            do_push = p && (mq.size() < 16 || f);
            if (f && mq.size() == 0) m_udf = 1'b1;
            if (p && mq.size() == 16 && !f) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({l, d});
`ifdef CKN_AD_BUF_STATS_EN
            if (do_push) m_push_cnt++;
            if (do_pop)  m_pop_cnt++;
`endif
        end
        #1;
        check_all(ctx);
        push_i = 1'b0; ckn_ad_fetch_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic idle_flush();
        step("flush", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int pushed, cyc;
        bit p, f, l;
        n_cmp = 0; n_err = 0;
        m_clear();
        iRstn = 1'b0; flush_i = 1'b0; push_i = 1'b0; push_last_i = 1'b0;
        ckn_ad_fetch_i = 1'b0; push_data_i = '0;
        #23;
        check_all("reset");
        @(negedge iClk);
        iRstn = 1'b1;

        // Three words, last on the third, no fetch.
        for (int i = 0; i < 3; i++)
            step("t1", 1'b1, 32'hA000_0000 + 32'(i), (i == 2), 1'b0, 1'b0);
        chk("t1.head", 64'(ckn_data_o), 64'({1'b0, 32'hA000_0000}));
        idle_flush();

        // Fill 16, then a dropped 17th, then drain in order.
        for (int i = 0; i < 17; i++)
            step("t2.fill", 1'b1, $urandom, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        for (int i = 0; i < 17; i++)
            step("t2.drain", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle_flush();

        // Full, then push+fetch in the same cycle.
        for (int i = 0; i < 16; i++)
            step("t3.fill", 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step("t3.pf", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        step("t3.pf2", 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
        idle_flush();

        // Fetch on empty with same-cycle push.
        step("t4", 1'b1, 32'hC0DE_0001, 1'b1, 1'b1, 1'b0);
        step("t4.hold", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        idle_flush();

        // Random stream of 40 accepted words with random fetch gaps.
        pushed = 0;
        cyc = 0;
        while (pushed < 40 && cyc < 400) begin
            p = ($urandom_range(0, 99) < 70);
            f = ($urandom_range(0, 99) < 50);
            l = ($urandom_range(0, 3) == 0);
            if (p && (mq.size() < 16 || f)) pushed++;
            step("t5", p, $urandom, l, f, 1'b0);
            cyc++;
        end
        chk("t5.budget", 64'(pushed >= 40), 64'd1);
        cyc = 0;
        while (mq.size() > 0 && cyc < 40) begin
            step("t5.drain", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            cyc++;
        end
        chk("t5.drained", 64'(level_o), 64'd0);

        // Flush with push, fetch and both errors active.
        step("t6.udf", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++)
            step("t6.fill", 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step("t6.flush", 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1);
        step("t6.after", 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);

        // Async reset mid-stream.
        for (int i = 0; i < 5; i++)
            step("t7.fill", 1'b1, $urandom, ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
        #1;
        iRstn = 1'b0;
        #1;
        m_clear();
        check_all("t7.arst");
        @(negedge iClk);
        iRstn = 1'b1;
        step("t7.post", 1'b1, 32'hFACE_0000, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
